// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one shared full-adder cell, one bit per clock, LSB first.

// One-bit full adder cell shared by the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cmsb;

    logic             accept_c;
    logic             run_c;
    logic             last_c;
    logic             fa_s_c;
    logic             fa_co_c;
    logic [WIDTH-1:0] acc_ext_c;

    // Shared cell sees the current LSBs and the stored carry.
    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s_c),
        .cout (fa_co_c)
    );

    assign accept_c  = (state == S_IDLE) && start;
    assign run_c     = (state == S_RUN);
    assign last_c    = run_c && (cnt == CNT_W'(WIDTH - 1));
    // acc holds completed low bits; prepending the new bit forms the shifted result.
    assign acc_ext_c = {fa_s_c, acc};

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Serial datapath: operand shifters, carry chain and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept_c) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            acc   <= '0;
        end else if (run_c) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_ext_c[WIDTH-1:1];
            carry <= fa_co_c;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 2)) begin
                cmsb <= fa_co_c;
            end
            if (last_c) begin
                sum  <= acc_ext_c;
                cout <= fa_co_c;
                ovf  <= fa_co_c ^ cmsb;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   edge_n    = 0;
    int   busy_end  = -1;
    int   next_free = 0;
    exp_t held      = '{sum: '0, cout: 1'b0, ovf: 1'b0};

    // Reference: plain integer add/subtract, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int   ux;
        int   uy;
        int   full;
        int   sx;
        int   sy;
        int   sr;
        ux   = int'(x);
        uy   = int'(y);
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        full = s ? (ux + ((2 ** W) - uy)) : (ux + uy);
        sr   = s ? (sx - sy) : (sx + sy);
        e.sum  = W'(full);
        e.cout = full[W];
        e.ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Model of acceptance: an op is taken when start is high and the unit is free.
    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            busy_end  = -1;
            next_free = 0;
            q.delete();
        end else if (start && edge_n >= next_free) begin
            q.push_back(model(a, b, sub));
            busy_end  = edge_n + W;
            next_free = edge_n + W + 2;
        end
    end

    // Monitor: checks busy/done timing every cycle and pops results on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = '{sum: '0, cout: 1'b0, ovf: 1'b0};
        end else begin
            check("busy", 32'(busy), 32'(edge_n <= busy_end));
            check("done", 32'(done), 32'(edge_n == busy_end));
            if (edge_n == busy_end) begin
                if (q.size() == 0) begin
                    check("sb_empty", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    held = e;
                end
            end else begin
                check("sum_hold", 32'(sum), 32'(held.sum));
                check("cout_hold", 32'(cout), 32'(held.cout));
                check("ovf_hold", 32'(ovf), 32'(held.ovf));
            end
        end
    end

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_sum"}, 32'(sum), 32'(0));
        check({tag, "_cout"}, 32'(cout), 32'(0));
        check({tag, "_ovf"}, 32'(ovf), 32'(0));
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        #1 chk_zero("por");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        op(8'h5A, 8'h3C, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
        op(8'h7F, 8'h01, 1'b0);
        op(8'h10, 8'h20, 1'b1);
        op(8'h80, 8'h01, 1'b1);
        op(8'h33, 8'h33, 1'b1);
        op(8'h00, 8'h00, 1'b1);

        // Mid-cycle reset while idle with random inputs and start asserted.
        @(posedge clk);
        #2;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'b1;
        rst_n = 1'b0;
        #1 chk_zero("rst_idle");
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Reset after three bits of a run: no done, outputs cleared.
        @(negedge clk);
        a = 8'hC3; b = 8'h5E; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_run");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        op(8'h01, 8'h02, 1'b0);

        for (int i = 0; i < 10; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
        end

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
